ps2_rx_deserializer: RTL

Receive-only PS/2 front end that turns raw keyboard `ps2_clock`/`ps2_data` line activity into validated scan-code bytes. It sits directly upstream of the keyboard interface stage, which watches for space make/break codes. It drives that stage's `received_data` / `received_data_en` byte stream and adds frame-error reporting and an inactivity watchdog.

---
 rtl/ps2_rx_deserializer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_deserializer.sv
// PS/2 receive front end: synchronizes and filters the raw keyboard lines, frames 11-bit
// packets into bytes, and flags bad frames and stalls. Define PS2_RX_PARITY_CHECK_EN to reject bad parity.
module ps2_rx_deserializer #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       inclock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       frame_error,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int         WD_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 2);
  localparam logic [3:0]      FILT_LAST = 4'(FILTER_LEN - 1);

  // Bit 0 is the PS/2 clock, bit 1 the PS/2 data line.
  logic [1:0] pin_raw;
  logic [1:0] pin_sync;

  assign pin_raw = {ps2_data, ps2_clock};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_q;
      logic sync_q;

      always_ff @(posedge inclock or posedge reset) begin
        if (reset) begin
          meta_q <= 1'b1;
          sync_q <= 1'b1;
        end else begin
          meta_q <= pin_raw[gi];
          sync_q <= meta_q;
        end
      end

      assign pin_sync[gi] = sync_q;
    end
  endgenerate

  logic       clk_s;
  logic       dat_s;
  assign clk_s = pin_sync[0];
  assign dat_s = pin_sync[1];

  // Clock deglitch: level only follows after FILTER_LEN consecutive disagreeing samples.
  logic       filt_q, filt_d;
  logic       filt_dly_q;
  logic [3:0] fcnt_q, fcnt_d;
  logic       strobe;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = 4'd0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FILT_LAST) begin
        filt_d = ~filt_q;
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      filt_q     <= 1'b1;
      filt_dly_q <= 1'b1;
      fcnt_q     <= 4'd0;
    end else begin
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      fcnt_q     <= fcnt_d;
    end
  end

  assign strobe = filt_dly_q & ~filt_q;

  logic [1:0]      state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [7:0]      data_q, data_d;
  logic            en_q, en_d;
  logic            err_q, err_d;
  logic            frame_ok;

`ifdef PS2_RX_PARITY_CHECK_EN
  logic parity_q, parity_d;
  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  assign frame_ok = dat_s & (^{shift_q, parity_q});
`else
  assign frame_ok = dat_s;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    en_d      = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
    parity_d  = parity_q;
`endif

    if (state_q == ST_IDLE || strobe) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end

    if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
          parity_d = dat_s;
`endif
          state_d  = ST_STOP;
        end
        default: begin
          if (frame_ok) begin
            data_d = shift_q;
            en_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE && wd_q == WD_LAST) begin
      // Sender stalled mid-frame: abandon it so the next start bit is seen cleanly.
      err_d     = 1'b1;
      state_d   = ST_IDLE;
      shift_d   = 8'h00;
      bit_cnt_d = 3'd0;
      wd_d      = '0;
    end
  end

  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      wd_q      <= '0;
      data_q    <= 8'h00;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      wd_q      <= wd_d;
      data_q    <= data_d;
      en_q      <= en_d;
      err_q     <= err_d;
`ifdef PS2_RX_PARITY_CHECK_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign received_data    = data_q;
  assign received_data_en = en_q;
  assign frame_error      = err_q;
  assign busy             = (state_q != ST_IDLE);

endmodule
